// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared widths and helpers for the multi-port register file
package regfile_mp_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   function automatic int reg_aw(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/regfile_mp_pc_delay.sv
// pc_delay_line: reset-clearable shift register aligning decode PCs with writeback
module pc_delay_line
   import regfile_mp_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int PC_DELAY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pc_o
);
   logic [PC_DELAY-1:0][ADDR_W-1:0] stage_q, stage_d;
   // shift one stage per cycle, newest PC enters stage 0
   always_comb begin
      stage_d[0] = pc_i;
      for (int i = 1; i < PC_DELAY; i++) stage_d[i] = stage_q[i-1];
   end
   // reset flushes every stage to zero
   always_ff @(posedge clk) stage_q <= reset ? '0 : stage_d;
   assign pc_o = stage_q[PC_DELAY-1];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, busy scoreboard and retirement trace
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int PC_DELAY = 4,
   localparam int REG_AW  = reg_aw(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*REG_AW-1:0] rd_num,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*REG_AW-1:0] wr_num,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [REG_AW-1:0]        iss_num,
   input  logic [ADDR_W-1:0]        pc,
   output logic                     trc_valid,
   output logic [ADDR_W-1:0]        trc_pc,
   output logic [REG_AW-1:0]        trc_num,
   output logic [DATA_W-1:0]        trc_data
);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_WR-1:0] wr_ok;
   logic [ADDR_W-1:0] wb_pc;
   logic trc_valid_q, trc_valid_d;
   logic [ADDR_W-1:0] trc_pc_q, trc_pc_d;
   logic [REG_AW-1:0] trc_num_q, trc_num_d;
   logic [DATA_W-1:0] trc_data_q, trc_data_d;

   pc_delay_line #(.ADDR_W(ADDR_W), .PC_DELAY(PC_DELAY)) u_pc_delay (
      .clk   (clk),
      .reset (reset),
      .pc_i  (pc),
      .pc_o  (wb_pc)
   );

   // a write is effective only when enabled and not aimed at x0
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) wr_ok[j] = wr_en[j] && (wr_num[j*REG_AW +: REG_AW] != '0);
   end

   // reads see stored value, overridden by the highest-index matching write this cycle
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_data[k*DATA_W +: DATA_W] = regs_q[rd_num[k*REG_AW +: REG_AW]];
         rd_busy[k] = busy_q[rd_num[k*REG_AW +: REG_AW]];
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j] && wr_num[j*REG_AW +: REG_AW] == rd_num[k*REG_AW +: REG_AW]) begin
               rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
               rd_busy[k] = 1'b0;
            end
         end
      end
   end

   // writes commit in port order so the higher index lands last; an issue re-marks busy after any clear
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_ok[j]) begin
            regs_d[wr_num[j*REG_AW +: REG_AW]] = wr_data[j*DATA_W +: DATA_W];
            busy_d[wr_num[j*REG_AW +: REG_AW]] = 1'b0;
         end
      end
      if (iss_en && iss_num != '0) busy_d[iss_num] = 1'b1;
   end

   // trace picks the lowest-index effective write; fields hold when nothing retires
   always_comb begin
      trc_valid_d = 1'b0;
      trc_pc_d = trc_pc_q;
      trc_num_d = trc_num_q;
      trc_data_d = trc_data_q;
      for (int j = NUM_WR - 1; j >= 0; j--) begin
         if (wr_ok[j]) begin
            trc_valid_d = 1'b1;
            trc_pc_d = wb_pc;
            trc_num_d = wr_num[j*REG_AW +: REG_AW];
            trc_data_d = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   // state update; reset clears contents, scoreboard and trace
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
         trc_valid_q <= 1'b0;
         trc_pc_q <= '0;
         trc_num_q <= '0;
         trc_data_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         trc_valid_q <= trc_valid_d;
         trc_pc_q <= trc_pc_d;
         trc_num_q <= trc_num_d;
         trc_data_q <= trc_data_d;
      end
   end

   assign trc_valid = trc_valid_q;
   assign trc_pc = trc_pc_q;
   assign trc_num = trc_num_q;
   assign trc_data = trc_data_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;
   localparam int DW = 32, PW = 32, NR = 32, RA = 5, NRD = 2, NWR = 2, PD = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NRD*RA-1:0] rd_num = '0;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0] rd_busy;
   logic [NWR-1:0] wr_en = '0;
   logic [NWR*RA-1:0] wr_num = '0;
   logic [NWR*DW-1:0] wr_data = '0;
   logic iss_en = 1'b0;
   logic [RA-1:0] iss_num = '0;
   logic [PW-1:0] pc = '0;
   logic trc_valid;
   logic [PW-1:0] trc_pc;
   logic [RA-1:0] trc_num;
   logic [DW-1:0] trc_data;

   regfile_mp #(.DATA_W(DW), .ADDR_W(PW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .PC_DELAY(PD)) dut (
      .clk(clk), .reset(reset), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .iss_en(iss_en), .iss_num(iss_num),
      .pc(pc), .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_num(trc_num), .trc_data(trc_data)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // model: architectural contents, busy set, PC history by cycle number, expected trace
   logic [DW-1:0] mem [NR];
   logic [NR-1:0] bsy;
   logic [PW-1:0] pc_log [4096];
   int cyc = 0, rst_cyc = 0;
   logic exp_tv;
   logic [PW-1:0] exp_pc;
   logic [RA-1:0] exp_num;
   logic [DW-1:0] exp_data;
   logic found;
   logic [RA-1:0] wn;

   always @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NR; r++) mem[r] = '0;
         bsy = '0;
         exp_tv = 1'b0; exp_pc = '0; exp_num = '0; exp_data = '0;
         rst_cyc = cyc;
      end else begin
         found = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            wn = wr_num[j*RA +: RA];
            if (wr_en[j] && wn != 0 && !found) begin
               found = 1'b1;
               exp_pc = (cyc - PD > rst_cyc) ? pc_log[(cyc - PD) % 4096] : '0;
               exp_num = wn;
               exp_data = wr_data[j*DW +: DW];
            end
         end
         exp_tv = found;
         for (int j = 0; j < NWR; j++) begin
            wn = wr_num[j*RA +: RA];
            if (wr_en[j] && wn != 0) begin
               mem[wn] = wr_data[j*DW +: DW];
               bsy[wn] = 1'b0;
            end
         end
         if (iss_en && iss_num != 0) bsy[iss_num] = 1'b1;
      end
      pc_log[cyc % 4096] = pc;
      cyc++;
   end

   logic [RA-1:0] c_rn;
   logic [DW-1:0] c_e;
   logic c_b;
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NRD; k++) begin
            c_rn = rd_num[k*RA +: RA];
            c_e = mem[c_rn];
            c_b = bsy[c_rn];
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && c_rn != 0 && wr_num[j*RA +: RA] == c_rn) begin
                  c_e = wr_data[j*DW +: DW];
                  c_b = 1'b0;
               end
            end
            chk($sformatf("rd_data%0d x%0d", k, c_rn), rd_data[k*DW +: DW], c_e);
            chk($sformatf("rd_busy%0d x%0d", k, c_rn), rd_busy[k], c_b);
         end
         chk("trc_valid", trc_valid, exp_tv);
         chk("trc_pc", trc_pc, exp_pc);
         chk("trc_num", trc_num, exp_num);
         chk("trc_data", trc_data, exp_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      pc = pc + 4;
   endtask

   task automatic idle();
      wr_en = '0;
      iss_en = 1'b0;
   endtask

   initial begin
      step();
      reset = 1'b0;
      for (int r = 0; r < NR; r++) begin
         rd_num = {RA'(r), RA'(r)};
         #2;
         chk("reset rd_data", rd_data, 64'd0);
         chk("reset rd_busy", rd_busy, 64'd0);
         chk("reset trc_valid", trc_valid, 64'd0);
         step();
      end
      wr_en = 2'b01; wr_num = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF}; rd_num = {5'd0, 5'd5};
      #2 chk("bypass x5", rd_data[31:0], 32'hDEADBEEF);
      step(); idle();
      #2 chk("stored x5", rd_data[31:0], 32'hDEADBEEF);
      chk("trace x5 valid", trc_valid, 1);
      chk("trace x5 num", trc_num, 5);
      wr_en = 2'b01; wr_num = '0; wr_data = {32'd0, 32'h1234}; iss_en = 1'b1; iss_num = 5'd0; rd_num = '0;
      #2 chk("x0 bypass", rd_data[31:0], 0);
      step(); idle();
      #2 chk("x0 read", rd_data[31:0], 0);
      chk("x0 busy", rd_busy[0], 0);
      chk("x0 no trace", trc_valid, 0);
      iss_en = 1'b1; iss_num = 5'd7; rd_num = {5'd0, 5'd7};
      step(); idle();
      step(); step(); step();
      chk("x7 busy", rd_busy[0], 1);
      wr_en = 2'b01; wr_num = {5'd0, 5'd7}; wr_data = {32'd0, 32'd77};
      #2 chk("x7 busy bypass", rd_busy[0], 0);
      step(); idle();
      #2 chk("x7 busy after", rd_busy[0], 0);
      iss_en = 1'b1; iss_num = 5'd9; wr_en = 2'b01; wr_num = {5'd0, 5'd9}; wr_data = {32'd0, 32'd99};
      step(); idle(); rd_num = {5'd0, 5'd9};
      #2 chk("x9 set wins", rd_busy[0], 1);
      wr_en = 2'b11; wr_num = {5'd3, 5'd3}; wr_data = {32'd2, 32'd1};
      step(); idle(); rd_num = {5'd3, 5'd3};
      #2 chk("x3 collision", rd_data[31:0], 2);
      chk("x3 trace data", trc_data, 1);
      chk("x3 trace num", trc_num, 3);
      reset = 1'b1;
      step();
      reset = 1'b0; pc = 32'h100;
      for (int i = 0; i < 4; i++) step();
      wr_en = 2'b01; wr_num = {5'd0, 5'd10}; wr_data = {32'd0, 32'hA5};
      step(); idle();
      #2 chk("trc_pc 0x100", trc_pc, 32'h100);
      reset = 1'b1;
      step();
      reset = 1'b0; pc = 32'h200;
      for (int i = 0; i < 4; i++) step();
      wr_en = 2'b01; wr_num = {5'd0, 5'd11}; wr_data = {32'd0, 32'h5A};
      step(); idle();
      #2 chk("trc_pc 0x200", trc_pc, 32'h200);
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         wr_en = NWR'($urandom);
         for (int j = 0; j < NWR; j++) begin
            wr_num[j*RA +: RA] = RA'($urandom_range(0, $urandom_range(0, 1) ? 3 : 31));
            wr_data[j*DW +: DW] = $urandom;
         end
         for (int k = 0; k < NRD; k++) rd_num[k*RA +: RA] = RA'($urandom_range(0, $urandom_range(0, 1) ? 3 : 31));
         iss_en = $urandom_range(0, 1) == 1;
         iss_num = RA'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) pc = $urandom;
         step();
      end
      reset = 1'b0; idle();
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
